// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: FSM controller for a multi-cycle MIPS-subset datapath
// (addu/subu/ori/lw/sw/beq/j/lui). Each instruction walks fetch, decode,
// execute, memory and writeback steps. Memory accesses stall on a ready
// handshake with an optional timeout. Retired instructions are counted.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous reset, active low
//   OpCode     IR[31:26]
//   funct      IR[5:0]
//   zero       ALU zero flag; the datapath gates PCWrCond with it
//   mem_ready  memory port completes the current MemR/MemW access
//   PCWr, PCWrCond, IorD, IRWr, MemR, MemW, RegW, RegDst, Mem2R, Alusrc,
//   ExtOp[1:0], Aluctrl[3:0], NPCop[1:0]   datapath strobes
//   instr_cnt  retired-instruction count, wraps
//   err        sticky fault (illegal opcode or memory timeout)
module multi_cycle_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWr,
    output logic             PCWrCond,
    output logic             IorD,
    output logic             IRWr,
    output logic             MemR,
    output logic             MemW,
    output logic             RegW,
    output logic             RegDst,
    output logic             Mem2R,
    output logic             Alusrc,
    output logic [1:0]       ExtOp,
    output logic [3:0]       Aluctrl,
    output logic [1:0]       NPCop,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             err
);

    localparam int unsigned WaitW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned WaitLast = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [WaitW-1:0] WaitLastV = WaitW'(WaitLast);

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0100;
    localparam logic [3:0] AluOr  = 4'b0101;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4,
        StErr = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               retire;
    logic               waiting;
    logic               timeout_hit;

    // The branch decision is taken in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    // Instruction decode from the held IR fields.
    logic is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_j, is_lui, legal;
    always_comb begin
        is_addu = (OpCode == 6'h00) && (funct == 6'h21);
        is_subu = (OpCode == 6'h00) && (funct == 6'h23);
        is_ori  = (OpCode == 6'h0D);
        is_lw   = (OpCode == 6'h23);
        is_sw   = (OpCode == 6'h2B);
        is_beq  = (OpCode == 6'h04);
        is_j    = (OpCode == 6'h02);
        is_lui  = (OpCode == 6'h0F);
        legal   = is_addu | is_subu | is_ori | is_lw | is_sw | is_beq | is_j | is_lui;
    end

    assign waiting     = ((state_q == StIf) || (state_q == StMem)) && !mem_ready;
    // Fires on the TIMEOUT_CYC-th consecutive not-ready cycle.
    assign timeout_hit = (TIMEOUT_CYC != 0) && waiting && (wait_q == WaitLastV);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIf;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            StIf: begin
                if (mem_ready) begin
                    state_d = StId;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StId: begin
                if (is_j) begin
                    state_d = StIf;
                    retire  = 1'b1;
                end else if (!legal) begin
                    state_d = StErr;
                end else begin
                    state_d = StEx;
                end
            end
            StEx: begin
                if (is_beq) begin
                    state_d = StIf;
                    retire  = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = StWb;
                    end else begin
                        state_d = StIf;
                        retire  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StWb: begin
                state_d = StIf;
                retire  = 1'b1;
            end
            StErr: state_d = StErr;
            default: state_d = StErr;
        endcase
        // Stall counter only survives while parked in the same stalled state.
        wait_d = (waiting && (state_d == state_q)) ? wait_q + 1'b1 : '0;
    end

    // Output logic; every strobe is held low while reset is asserted.
    always_comb begin
        PCWr     = 1'b0;
        PCWrCond = 1'b0;
        IorD     = 1'b0;
        IRWr     = 1'b0;
        MemR     = 1'b0;
        MemW     = 1'b0;
        RegW     = 1'b0;
        RegDst   = 1'b0;
        Mem2R    = 1'b0;
        Alusrc   = 1'b0;
        ExtOp    = 2'b00;
        Aluctrl  = AluAdd;
        NPCop    = 2'b00;
        if (rst_n) begin
            unique case (state_q)
                StIf: begin
                    MemR = 1'b1;
                    if (mem_ready) begin
                        IRWr = 1'b1;
                        PCWr = 1'b1;
                    end
                end
                StId: begin
                    if (is_j) begin
                        PCWr  = 1'b1;
                        NPCop = 2'b01;
                    end
                end
                StEx: begin
                    if (is_subu || is_beq) begin
                        Aluctrl = AluSub;
                    end else if (is_ori || is_lui) begin
                        Aluctrl = AluOr;
                    end
                    Alusrc = is_ori | is_lw | is_sw | is_lui;
                    if (is_lw || is_sw || is_beq) begin
                        ExtOp = 2'b01;
                    end else if (is_lui) begin
                        ExtOp = 2'b10;
                    end
                    if (is_beq) begin
                        PCWrCond = 1'b1;
                        NPCop    = 2'b10;
                    end
                end
                StMem: begin
                    IorD = 1'b1;
                    MemR = is_lw;
                    MemW = is_sw;
                end
                StWb: begin
                    RegW   = 1'b1;
                    RegDst = is_ori | is_lw | is_lui;
                    Mem2R  = is_lw;
                end
                default: ;
            endcase
        end
    end

    assign instr_cnt = cnt_q;
    assign err       = (state_q == StErr);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed scenarios with literal
// expectations, then randomized traffic against an instruction-level model.
module tb_multi_cycle_ctrl;

    localparam int unsigned TO = 8;
    localparam int unsigned CW = 6;

    // Instruction classes
    localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LW = 3, C_SW = 4;
    localparam int C_BEQ = 5, C_J = 6, C_LUI = 7, C_ILL = 8;
    // Step kinds
    localparam int K_F = 0, K_D = 1, K_E = 2, K_M = 3, K_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, zero, mem_ready;
    logic [5:0]    OpCode, funct;
    logic          PCWr, PCWrCond, IorD, IRWr, MemR, MemW, RegW, RegDst, Mem2R, Alusrc;
    logic [1:0]    ExtOp, NPCop;
    logic [3:0]    Aluctrl;
    logic [CW-1:0] instr_cnt;
    logic          err;

    multi_cycle_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD),
        .IRWr(IRWr), .MemR(MemR), .MemW(MemW), .RegW(RegW), .RegDst(RegDst),
        .Mem2R(Mem2R), .Alusrc(Alusrc), .ExtOp(ExtOp), .Aluctrl(Aluctrl),
        .NPCop(NPCop), .instr_cnt(instr_cnt), .err(err)
    );

    int errors = 0;
    int checks = 0;

    // Model: current instruction class, position in its step list, counters.
    int m_cls   = C_ADDU;
    int m_pos   = 0;
    int m_wait  = 0;
    int m_cnt   = 0;
    bit m_err   = 1'b0;
    bit m_valid = 1'b0;

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: return (fn == 6'h21) ? C_ADDU : (fn == 6'h23) ? C_SUBU : C_ILL;
            6'h0D: return C_ORI;
            6'h23: return C_LW;
            6'h2B: return C_SW;
            6'h04: return C_BEQ;
            6'h02: return C_J;
            6'h0F: return C_LUI;
            default: return C_ILL;
        endcase
    endfunction

    function automatic int seq_len(input int c);
        if (c == C_J || c == C_ILL) return 2;
        if (c == C_BEQ) return 3;
        if (c == C_LW) return 5;
        return 4;
    endfunction

    function automatic int step_at(input int c, input int p);
        case (p)
            0: return K_F;
            1: return K_D;
            2: return K_E;
            3: return (c == C_LW || c == C_SW) ? K_M : K_W;
            default: return K_W;
        endcase
    endfunction

    // {PCWr,PCWrCond,IorD,IRWr,MemR,MemW,RegW,RegDst,Mem2R,Alusrc,ExtOp,Aluctrl,NPCop}
    function automatic logic [17:0] exp_strobes(input logic rst, input bit e, input int c,
                                                input int p, input logic rdy);
        logic pcwr, pcc, iord, irwr, memr, memw, regw, rdst, m2r, asrc;
        logic [1:0] ext, npc;
        logic [3:0] alu;
        {pcwr, pcc, iord, irwr, memr, memw, regw, rdst, m2r, asrc} = '0;
        ext = 2'b00; npc = 2'b00; alu = 4'b0000;
        if (!rst || e) return '0;
        case (step_at(c, p))
            K_F: begin
                memr = 1'b1;
                if (rdy) begin irwr = 1'b1; pcwr = 1'b1; end
            end
            K_D: if (c == C_J) begin pcwr = 1'b1; npc = 2'b01; end
            K_E: begin
                if (c == C_SUBU || c == C_BEQ) alu = 4'b0100;
                if (c == C_ORI || c == C_LUI) alu = 4'b0101;
                asrc = (c == C_ORI || c == C_LW || c == C_SW || c == C_LUI);
                if (c == C_LW || c == C_SW || c == C_BEQ) ext = 2'b01;
                if (c == C_LUI) ext = 2'b10;
                if (c == C_BEQ) begin pcc = 1'b1; npc = 2'b10; end
            end
            K_M: begin
                iord = 1'b1;
                memr = (c == C_LW);
                memw = (c == C_SW);
            end
            default: begin
                regw = 1'b1;
                rdst = (c == C_ORI || c == C_LW || c == C_LUI);
                m2r  = (c == C_LW);
            end
        endcase
        return {pcwr, pcc, iord, irwr, memr, memw, regw, rdst, m2r, asrc, ext, alu, npc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [17:0] act, exp;
        act = {PCWr, PCWrCond, IorD, IRWr, MemR, MemW, RegW, RegDst, Mem2R, Alusrc,
               ExtOp, Aluctrl, NPCop};
        exp = exp_strobes(rst_n, m_err, m_cls, m_pos, mem_ready);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL strobes cls=%0d pos=%0d: got %05h expected %05h at %0t",
                     m_cls, m_pos, act, exp, $time);
        end
        if (m_valid) begin
            chk("err", 32'(err), 32'(m_err));
            chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt % (1 << CW)));
        end
    endtask

    task automatic model_step();
        int k;
        if (!rst_n) begin
            m_pos = 0; m_wait = 0; m_cnt = 0; m_err = 1'b0; m_valid = 1'b1;
            return;
        end
        if (!m_valid || m_err) return;
        k = step_at(m_cls, m_pos);
        if ((k == K_F || k == K_M) && !mem_ready) begin
            m_wait++;
            if (TO != 0 && m_wait == int'(TO)) m_err = 1'b1;
            return;
        end
        m_wait = 0;
        if (k == K_F) m_cls = classify(OpCode, funct);
        m_pos++;
        if (m_pos == seq_len(m_cls)) begin
            m_pos = 0;
            if (m_cls == C_ILL) m_err = 1'b1;
            else m_cnt++;
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    logic [5:0] ops [8] = '{6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h0F};

    initial begin
        int stall;
        int err_cycles;
        int idx;
        rst_n = 1'b0; OpCode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        chk("rst_cnt", 32'(instr_cnt), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_memr", 32'(MemR), 0);
        rst_n = 1'b1;
        #1;
        chk("if_memr", 32'(MemR), 1);

        // addu, no waits: 4 cycles
        OpCode = 6'h00; funct = 6'h21;
        tick(); tick(); tick();
        chk("addu_wb_regw", 32'(RegW), 1);
        chk("addu_wb_regdst", 32'(RegDst), 0);
        chk("addu_wb_alu", 32'(Aluctrl), 0);
        tick();
        chk("addu_cnt", 32'(instr_cnt), 1);

        // lw with two wait cycles in the memory step: 7 cycles
        OpCode = 6'h23;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        chk("lw_memr0", 32'(MemR), 1);
        chk("lw_iord0", 32'(IorD), 1);
        tick();
        chk("lw_memr1", 32'(MemR), 1);
        tick();
        mem_ready = 1'b1;
        chk("lw_memr2", 32'(MemR), 1);
        tick();
        chk("lw_mem2r", 32'(Mem2R), 1);
        chk("lw_regdst", 32'(RegDst), 1);
        tick();
        chk("lw_cnt", 32'(instr_cnt), 2);

        // beq taken and not taken: identical strobes
        for (int z = 1; z >= 0; z--) begin
            OpCode = 6'h04; zero = z[0];
            tick(); tick();
            chk("beq_pcwrcond", 32'(PCWrCond), 1);
            chk("beq_npcop", 32'(NPCop), 2);
            chk("beq_alu", 32'(Aluctrl), 4);
            chk("beq_extop", 32'(ExtOp), 1);
            tick();
        end
        chk("beq_cnt", 32'(instr_cnt), 4);

        // illegal opcode locks into the error state until reset
        OpCode = 6'h3F;
        tick(); tick();
        chk("ill_err", 32'(err), 1);
        chk("ill_regw", 32'(RegW), 0);
        chk("ill_memw", 32'(MemW), 0);
        repeat (5) begin mem_ready = 1'($urandom); tick(); end
        chk("ill_err_hold", 32'(err), 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1; mem_ready = 1'b1;
        chk("ill_rst_err", 32'(err), 0);
        chk("ill_rst_cnt", 32'(instr_cnt), 0);

        // fetch timeout after TO not-ready cycles
        OpCode = 6'h0F; mem_ready = 1'b0;
        repeat (TO - 1) tick();
        chk("to_pre", 32'(err), 0);
        tick();
        chk("to_err", 32'(err), 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        repeat (TO - 1) tick();
        mem_ready = 1'b1;
        tick();
        chk("to_ready_err", 32'(err), 0);
        chk("to_ready_memr", 32'(MemR), 0);
        tick(); tick(); tick();
        chk("to_lui_cnt", 32'(instr_cnt), 1);

        // reset mid-store drops MemW at once
        OpCode = 6'h2B;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        chk("sw_memw", 32'(MemW), 1);
        rst_n = 1'b0;
        #1;
        chk("sw_rst_memw", 32'(MemW), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("sw_rst_cnt", 32'(instr_cnt), 0);
        chk("sw_rst_if", 32'(MemR), 1);

        // randomized traffic
        stall = 0; err_cycles = 0;
        repeat (4000) begin
            if (m_err) begin
                err_cycles++;
                rst_n = (err_cycles < 3);
                if (!rst_n) err_cycles = 0;
            end else begin
                rst_n = ($urandom_range(0, 99) != 0);
            end
            if (stall > 0) begin
                mem_ready = 1'b0; stall--;
            end else if ($urandom_range(0, 29) == 0) begin
                stall = $urandom_range(5, 9); mem_ready = 1'b0;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            zero = 1'($urandom);
            if (!m_err && step_at(m_cls, m_pos) == K_F) begin
                if ($urandom_range(0, 24) == 0) begin
                    OpCode = 6'($urandom); funct = 6'($urandom);
                end else begin
                    idx = $urandom_range(0, 7);
                    OpCode = ops[idx];
                    funct = (idx < 2) ? ((idx == 0) ? 6'h21 : 6'h23) : 6'($urandom);
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
